// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, exception codes and field positions
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_OV   = 5'h0c
    } exc_code_e;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int CA_TI  = 30;
    localparam int CA_BD  = 31;

    localparam int EV_ADES    = 0;
    localparam int EV_ADEL    = 1;
    localparam int EV_BP      = 2;
    localparam int EV_SYS     = 3;
    localparam int EV_OV      = 4;
    localparam int EV_RI      = 5;
    localparam int EV_IF_ADEL = 6;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] PRID_VALUE   = 32'h0000_4220;
    localparam logic [31:0] CONFIG_VALUE = 32'h8000_0000;

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with clock divider and timer-interrupt flag
module cp0_timer #(
    parameter int TIMER_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int DIV_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TIMER_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             ti_q, ti_d;
    logic             tick;

    always_comb begin
        tick      = (div_q == DIV_LAST);
        div_d     = tick ? '0 : div_q + 1'b1;
        count_d   = count_q;
        if (count_we)
            count_d = wdata;
        else if (tick)
            count_d = count_q + 32'd1;
        compare_d = compare_we ? wdata : compare_q;
        // A Compare write acknowledges the timer even if a match lands on the same cycle
        ti_d      = compare_we ? 1'b0 : (ti_q | (count_q == compare_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_ctrl.sv
// rtl/cp0_ctrl.sv - MIPS32 CP0 commit-stage controller; CP0_CONFIG_EN adds PRId/Config
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int          HW_INT_NUM      = 6,
    parameter int          TIMER_DIV       = 2,
    parameter logic [31:0] EXC_VECTOR      = 32'hbfc00380,
    parameter int          INT_SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  commit_valid,
    input  logic [31:0]           commit_pc,
    input  logic                  commit_bd,
    input  logic [6:0]            exc_vec,
    input  logic [31:0]           bad_addr,
    input  logic                  inst_eret,
    input  logic                  mtc0_we,
    input  logic                  mfc0_re,
    input  logic [4:0]            cp0_addr,
    input  logic [31:0]           mtc0_wdata,
    input  logic [HW_INT_NUM-1:0] hw_int,
    output logic [31:0]           cp0_rdata,
    output logic                  flush,
    output logic [31:0]           new_pc,
    output logic                  timer_int
);

    logic [INT_SYNC_STAGES-1:0][HW_INT_NUM-1:0] sync_q, sync_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic [31:0] count, compare;
    logic        ti;
    logic [7:0]  ip;
    logic        int_req, exc_taken, wr_en, bad_we;
    logic [31:0] bad_val, status_rd, cause_rd;
    exc_code_e   exc_sel;

    cp0_timer #(.TIMER_DIV(TIMER_DIV)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_we   (wr_en && (cp0_addr == CP0_COUNT)),
        .compare_we (wr_en && (cp0_addr == CP0_COMPARE)),
        .wdata      (mtc0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_comb begin
        sync_d[0] = hw_int;
        for (int i = 1; i < INT_SYNC_STAGES; i++)
            sync_d[i] = sync_q[i-1];
        ip_hw_d = '0;
        ip_hw_d[HW_INT_NUM-1:0] = sync_q[INT_SYNC_STAGES-1];
        // IP7 is shared between the timer and the sixth hardware line
        ip        = {ti | ip_hw_q[5], ip_hw_q[4:0], ip_sw_q};
        int_req   = (|(ip & im_q)) & ie_q & ~exl_q;
        exc_taken = commit_valid & (int_req | (|exc_vec));
        wr_en     = mtc0_we & ~exc_taken;
    end

    always_comb begin
        exc_sel = EXC_INT;
        bad_we  = 1'b0;
        bad_val = bad_addr;
        if (int_req)                  exc_sel = EXC_INT;
        else if (exc_vec[EV_IF_ADEL]) begin exc_sel = EXC_ADEL; bad_we = 1'b1; bad_val = commit_pc; end
        else if (exc_vec[EV_RI])      exc_sel = EXC_RI;
        else if (exc_vec[EV_OV])      exc_sel = EXC_OV;
        else if (exc_vec[EV_SYS])     exc_sel = EXC_SYS;
        else if (exc_vec[EV_BP])      exc_sel = EXC_BP;
        else if (exc_vec[EV_ADEL])    begin exc_sel = EXC_ADEL; bad_we = 1'b1; end
        else if (exc_vec[EV_ADES])    begin exc_sel = EXC_ADES; bad_we = 1'b1; end
    end

    always_comb begin
        ip_sw_d    = ip_sw_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        if (exc_taken) begin
            // Nested exceptions keep the original return point
            if (!exl_q) begin
                epc_d = commit_bd ? commit_pc - 32'd4 : commit_pc;
                bd_d  = commit_bd;
            end
            exl_d      = 1'b1;
            exc_code_d = exc_sel;
            if (bad_we)
                badvaddr_d = bad_val;
        end else begin
            if (wr_en) begin
                case (cp0_addr)
                    CP0_STATUS: begin
                        im_d  = mtc0_wdata[15:8];
                        exl_d = mtc0_wdata[ST_EXL];
                        ie_d  = mtc0_wdata[ST_IE];
                    end
                    CP0_CAUSE: ip_sw_d = mtc0_wdata[9:8];
                    CP0_EPC:   epc_d   = mtc0_wdata;
                    default: ;
                endcase
            end
            if (inst_eret)
                exl_d = 1'b0;
        end
    end

    always_comb begin
        status_rd         = STATUS_RESET;
        status_rd[15:8]   = im_q;
        status_rd[ST_EXL] = exl_q;
        status_rd[ST_IE]  = ie_q;
        cause_rd          = '0;
        cause_rd[CA_BD]   = bd_q;
        cause_rd[CA_TI]   = ti;
        cause_rd[15:8]    = ip;
        cause_rd[6:2]     = exc_code_q;
        cp0_rdata = '0;
        if (mfc0_re) begin
            case (cp0_addr)
                CP0_BADVADDR: cp0_rdata = badvaddr_q;
                CP0_COUNT:    cp0_rdata = count;
                CP0_COMPARE:  cp0_rdata = compare;
                CP0_STATUS:   cp0_rdata = status_rd;
                CP0_CAUSE:    cp0_rdata = cause_rd;
                CP0_EPC:      cp0_rdata = epc_q;
`ifdef CP0_CONFIG_EN
                CP0_PRID:     cp0_rdata = PRID_VALUE;
                CP0_CONFIG:   cp0_rdata = CONFIG_VALUE;
`endif
                default:      cp0_rdata = '0;
            endcase
        end
        flush  = exc_taken | inst_eret;
        new_pc = exc_taken ? EXC_VECTOR : (inst_eret ? epc_q : 32'd0);
    end

    assign timer_int = ti;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            sync_q     <= sync_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb/tb_cp0_ctrl.sv - randomized and directed self-checking bench for cp0_ctrl
module tb_cp0_ctrl;

    localparam int          HW_INT_NUM      = 6;
    localparam int          TIMER_DIV       = 2;
    localparam int          INT_SYNC_STAGES = 2;
    localparam logic [31:0] EXC_VECTOR      = 32'hbfc00380;

    logic                  clk, rst_n;
    logic                  commit_valid, commit_bd, inst_eret, mtc0_we, mfc0_re;
    logic [31:0]           commit_pc, bad_addr, mtc0_wdata;
    logic [6:0]            exc_vec;
    logic [4:0]            cp0_addr;
    logic [HW_INT_NUM-1:0] hw_int;
    logic [31:0]           cp0_rdata, new_pc;
    logic                  flush, timer_int;

    cp0_ctrl #(
        .HW_INT_NUM      (HW_INT_NUM),
        .TIMER_DIV       (TIMER_DIV),
        .EXC_VECTOR      (EXC_VECTOR),
        .INT_SYNC_STAGES (INT_SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_bd    (commit_bd),
        .exc_vec      (exc_vec),
        .bad_addr     (bad_addr),
        .inst_eret    (inst_eret),
        .mtc0_we      (mtc0_we),
        .mfc0_re      (mfc0_re),
        .cp0_addr     (cp0_addr),
        .mtc0_wdata   (mtc0_wdata),
        .hw_int       (hw_int),
        .cp0_rdata    (cp0_rdata),
        .flush        (flush),
        .new_pc       (new_pc),
        .timer_int    (timer_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Architectural reference state
    logic [31:0]           m_count, m_compare, m_status, m_cause, m_epc, m_badv;
    logic                  m_ti;
    int                    m_cyc;
    logic [HW_INT_NUM-1:0] hist[$];

    function automatic logic [7:0] m_ip();
        logic [5:0] h = '0;
        if (hist.size() == INT_SYNC_STAGES + 1)
            h[HW_INT_NUM-1:0] = hist[0];
        return {m_ti | h[5], h[4:0], m_cause[9:8]};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_badv;
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return (m_cause & 32'h8000_007c) | ({24'd0, m_ip()} << 8) | ({31'd0, m_ti} << 30);
            5'd14: return m_epc;
`ifdef CP0_CONFIG_EN
            5'd15: return 32'h0000_4220;
            5'd16: return 32'h8000_0000;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Exception decision: returns taken, ExcCode and BadVAddr source (0 none, 1 pc, 2 data)
    function automatic void m_exc(output logic taken, output logic [4:0] code, output int bsrc);
        logic [4:0] codes[7] = '{5'h05, 5'h04, 5'h09, 5'h08, 5'h0c, 5'h0a, 5'h04};
        int         srcs[7]  = '{2, 2, 0, 0, 0, 0, 1};
        logic irq;
        irq   = (|(m_ip() & m_status[15:8])) & m_status[0] & ~m_status[1];
        taken = commit_valid & (irq | (|exc_vec));
        code  = 5'h00;
        bsrc  = 0;
        if (!irq) begin
            for (int b = 0; b < 7; b++) begin
                if (exc_vec[b]) begin
                    code = codes[b];
                    bsrc = srcs[b];
                end
            end
        end
    endfunction

    task automatic m_reset();
        m_count = 0; m_compare = 0; m_status = 32'h0040_0000; m_cause = 0;
        m_epc = 0; m_badv = 0; m_ti = 0; m_cyc = 0;
        hist.delete();
    endtask

    task automatic m_step();
        logic taken, wr, tick, n_ti;
        logic [4:0] code;
        logic [31:0] n_count, n_compare;
        int bsrc;
        m_exc(taken, code, bsrc);
        wr        = mtc0_we & ~taken;
        tick      = (m_cyc % TIMER_DIV) == (TIMER_DIV - 1);
        n_ti      = (wr && cp0_addr == 5'd11) ? 1'b0 : (m_ti | (m_count == m_compare));
        n_count   = (wr && cp0_addr == 5'd9) ? mtc0_wdata : (tick ? m_count + 1 : m_count);
        n_compare = (wr && cp0_addr == 5'd11) ? mtc0_wdata : m_compare;
        if (taken) begin
            if (!m_status[1]) begin
                m_epc      = commit_bd ? commit_pc - 4 : commit_pc;
                m_cause[31] = commit_bd;
            end
            m_status[1] = 1'b1;
            m_cause     = (m_cause & ~32'h0000_007c) | ({27'd0, code} << 2);
            if (bsrc == 1) m_badv = commit_pc;
            if (bsrc == 2) m_badv = bad_addr;
        end else begin
            if (wr && cp0_addr == 5'd12) m_status = 32'h0040_0000 | (mtc0_wdata & 32'h0000_ff03);
            if (wr && cp0_addr == 5'd13) m_cause  = (m_cause & ~32'h0000_0300) | (mtc0_wdata & 32'h0000_0300);
            if (wr && cp0_addr == 5'd14) m_epc    = mtc0_wdata;
            if (inst_eret) m_status[1] = 1'b0;
        end
        m_ti = n_ti; m_count = n_count; m_compare = n_compare;
        hist.push_back(hw_int);
        while (hist.size() > INT_SYNC_STAGES + 1) void'(hist.pop_front());
        m_cyc++;
    endtask

    logic        obs_flush;
    logic [31:0] obs_pc, obs_rdata;

    task automatic do_cycle();
        logic taken;
        logic [4:0] code;
        int bsrc;
        @(negedge clk);
        m_exc(taken, code, bsrc);
        obs_flush = flush; obs_pc = new_pc; obs_rdata = cp0_rdata;
        chk("flush", flush, taken | inst_eret);
        chk("new_pc", new_pc, taken ? EXC_VECTOR : (inst_eret ? m_epc : 32'd0));
        chk("rdata", cp0_rdata, mfc0_re ? m_read(cp0_addr) : 32'd0);
        chk("timer_int", timer_int, m_ti);
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic idle();
        commit_valid = 0; commit_pc = 0; commit_bd = 0; exc_vec = 0; bad_addr = 0;
        inst_eret = 0; mtc0_we = 0; mfc0_re = 0; cp0_addr = 0; mtc0_wdata = 0; hw_int = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle(); mtc0_we = 1; cp0_addr = a; mtc0_wdata = d;
        do_cycle(); idle();
    endtask

    task automatic mfc0(input logic [4:0] a, output logic [31:0] d);
        idle(); mfc0_re = 1; cp0_addr = a;
        do_cycle(); d = obs_rdata; idle();
    endtask

    task automatic do_reset();
        logic [4:0] ra[4] = '{5'd9, 5'd12, 5'd13, 5'd14};
        logic [31:0] rv[4] = '{32'd0, 32'h0040_0000, 32'd0, 32'd0};
        @(posedge clk);
        #3;
        idle();
        rst_n = 0;
        mfc0_re = 1;
        for (int i = 0; i < 4; i++) begin
            cp0_addr = ra[i];
            #1;
            chk("reset_reg", cp0_rdata, rv[i]);
        end
        chk("reset_flush", flush, 0);
        chk("reset_new_pc", new_pc, 0);
        chk("reset_ti", timer_int, 0);
        idle();
        m_reset();
        @(posedge clk);
        #2;
        rst_n = 1;
    endtask

    logic [31:0] d, bv0;
    logic [HW_INT_NUM-1:0] hw_keep;
    logic [4:0] addrs[9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
    int k;

    initial begin
        rst_n = 0;
        idle();
        m_reset();
        do_reset();

        // Timer match and clear
        mtc0(5'd11, 32'd5);
        k = 0;
        while (!timer_int && k < 40) begin idle(); do_cycle(); k++; end
        chk("ti_set", timer_int, 1);
        mfc0(5'd9, d);
        chk("ti_count", (d == 32'd5) || (d == 32'd6), 1);
        mtc0(5'd11, 32'd20);
        chk("ti_clear", timer_int, 0);

        // Timer interrupt taken
        mtc0(5'd12, 32'h0000_8001);
        k = 0;
        while (!timer_int && k < 80) begin idle(); do_cycle(); k++; end
        chk("ti_pending", timer_int, 1);
        idle(); commit_valid = 1; commit_pc = 32'h8000_1000;
        do_cycle(); idle();
        chk("int_flush", obs_flush, 1);
        chk("int_new_pc", obs_pc, 32'hbfc00380);
        mfc0(5'd14, d); chk("int_epc", d, 32'h8000_1000);
        mfc0(5'd13, d); chk("int_code", (d >> 2) & 32'h1f, 0);
        mfc0(5'd12, d); chk("int_exl", d[1], 1);

        // ERET back, then ov+ades in a delay slot
        idle(); inst_eret = 1; do_cycle(); idle();
        chk("eret_pc", obs_pc, 32'h8000_1000);
        mtc0(5'd12, 32'd0);
        mfc0(5'd8, bv0);
        idle(); commit_valid = 1; exc_vec = 7'b0010001; commit_bd = 1;
        commit_pc = 32'h8000_2004; bad_addr = $urandom;
        do_cycle(); idle();
        mfc0(5'd13, d); chk("ov_code", (d >> 2) & 32'h1f, 32'hc); chk("ov_bd", d[31], 1);
        mfc0(5'd14, d); chk("ov_epc", d, 32'h8000_2000);
        mfc0(5'd8, d);  chk("ov_badv", d, bv0);

        // ades alone, then ERET
        idle(); inst_eret = 1; do_cycle(); idle();
        idle(); commit_valid = 1; exc_vec = 7'b0000001; commit_pc = 32'h8000_3000;
        bad_addr = 32'h1234_5671;
        do_cycle(); idle();
        mfc0(5'd13, d); chk("ades_code", (d >> 2) & 32'h1f, 5);
        mfc0(5'd8, d);  chk("ades_badv", d, 32'h1234_5671);
        idle(); inst_eret = 1; do_cycle(); idle();
        chk("ades_eret_pc", obs_pc, 32'h8000_3000);
        mfc0(5'd12, d); chk("ades_exl", d[1], 0);

        // Synchronised hardware interrupt latency, then masked by EXL
        mtc0(5'd12, 32'h0000_0401);
        k = 0;
        do begin
            idle(); commit_valid = 1; hw_int = 1;
            do_cycle(); k++;
        end while (!obs_flush && k < 20);
        chk("hw_taken", obs_flush, 1);
        chk("hw_latency", k >= INT_SYNC_STAGES + 2, 1);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            idle(); commit_valid = 1; hw_int = 1;
            do_cycle();
            if (obs_flush) k++;
        end
        chk("hw_exl_block", k, 0);
        idle(); inst_eret = 1; do_cycle();
        mtc0(5'd12, 32'd0);

        // Count write on an increment cycle, then wrap
        k = 0;
        while ((m_cyc % TIMER_DIV) != (TIMER_DIV - 1) && k < 10) begin idle(); do_cycle(); k++; end
        mtc0(5'd9, 32'hffff_ffff);
        mfc0(5'd9, d); chk("count_write", d, 32'hffff_ffff);
        repeat (TIMER_DIV - 1) begin idle(); do_cycle(); end
        mfc0(5'd9, d); chk("count_wrap", d, 32'd0);

        // Randomized traffic against the reference model
        hw_keep = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            idle();
            commit_valid = ($urandom_range(0, 3) == 0);
            commit_pc    = $urandom & 32'hffff_fffc;
            commit_bd    = 1'($urandom);
            exc_vec      = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
            bad_addr     = $urandom;
            inst_eret    = ($urandom_range(0, 15) == 0);
            mtc0_we      = ($urandom_range(0, 3) == 0);
            mfc0_re      = 1'($urandom);
            cp0_addr     = addrs[$urandom_range(0, 8)];
            mtc0_wdata   = $urandom;
            if (cp0_addr == 5'd11 && $urandom_range(0, 1) == 1)
                mtc0_wdata = m_count + $urandom_range(0, 8);
            if ($urandom_range(0, 7) == 0) hw_keep = HW_INT_NUM'($urandom);
            hw_int = hw_keep;
            do_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
- Parametrised MIPS32 coprocessor-0 for the commit stage: Count/Compare timer, BadVAddr, Status, Cause, EPC.
- Generalises the previous CP0 with a configurable hardware-interrupt count, a configurable timer divider, priority-encoded simultaneous exceptions, synchronised interrupt inputs and a programmable exception vector.
- Drives redirect PC and pipeline flush on exception or ERET.

Parameters:
HW_INT_NUM, 6, hardware interrupt lines (1..6), mapped to Cause.IP[2+HW_INT_NUM-1:2]
TIMER_DIV, 2, clock cycles per Count increment (>=1)
EXC_VECTOR, 32'hbfc00380, exception redirect address
INT_SYNC_STAGES, 2, synchroniser flops on hw_int (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
commit_valid  in  1  instruction present in commit stage
commit_pc  in  32  PC of committing instruction
commit_bd  in  1  instruction is in a delay slot
exc_vec  in  7  {if_adel, ri, ov, sys, bp, adel, ades}
bad_addr  in  32  data address for adel/ades
inst_eret  in  1  ERET committing
mtc0_we  in  1  MTC0 committing
mfc0_re  in  1  MFC0 read request
cp0_addr  in  5  register number
mtc0_wdata  in  32  write data
hw_int  in  HW_INT_NUM  asynchronous interrupt requests
cp0_rdata  out  32  read data
flush  out  1  flush pipeline
new_pc  out  32  redirect target
timer_int  out  1  Cause.TI

Behaviour:
- Reset values:
  - Status = 32'h0040_0000 (BEV=1).
  - Count, Compare, Cause, EPC, BadVAddr, divider and synchronisers = 0.
  - Outputs: flush=0, new_pc=0, timer_int=0.
- Divider counts 0..TIMER_DIV-1. Count increments on the cycle the divider equals TIMER_DIV-1 and wraps at 2^32.
- Timer:
  - Count==Compare sets Cause.TI (bit 30) and holds it.
  - An MTC0 to Compare clears TI and wins over a same-cycle match.
  - IP7 = TI | (HW_INT_NUM==6 ? hw_int_sync[5] : 0).
- Interrupts:
  - hw_int passes INT_SYNC_STAGES flops, then is written to IP[2+i] every cycle.
  - IP[1:0] are written only by MTC0 Cause; unused IP bits read 0.
- int_req = |(Cause.IP & Status.IM) & Status.IE & ~Status.EXL. Acted on only when commit_valid=1.
- Exception taken when commit_valid & (int_req | |exc_vec). Priority, highest first (ExcCode):
  - Int 0x0
  - if_adel 0x4, BadVAddr=commit_pc
  - ri 0xA
  - ov 0xC
  - sys 0x8
  - bp 0x9
  - adel 0x4, BadVAddr=bad_addr
  - ades 0x5, BadVAddr=bad_addr
- On a taken exception:
  - If EXL=0: EPC = commit_bd ? commit_pc-4 : commit_pc; Cause.BD = commit_bd.
  - Always: EXL=1 and ExcCode is written.
  - BadVAddr is updated only for address errors.
  - A same-cycle MTC0 or ERET is suppressed.
- ERET without an exception clears EXL.
- flush and new_pc are combinational, same cycle:
  - exception: EXC_VECTOR
  - ERET: EPC
  - otherwise: 0
- MTC0 priority:
  - An MTC0 to Count overrides the increment in that cycle.
  - Writable fields:
    - Status: IM[15:8], EXL[1], IE[0]; BEV is fixed at 1.
    - Cause: IP[9:8] only.
    - EPC and Compare: full width.
  - Writes to BadVAddr and to unimplemented addresses are ignored.
- MFC0 read is combinational:
  - 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC; others read 0.
  - A read in the cycle of a write returns the old value.
  - cp0_rdata = 0 when mfc0_re=0.
- Reset asserted mid-operation returns every register to its reset value immediately.

Optional Feature:
- CP0_CONFIG_EN defined:
  - Read-only PRId (15) = 32'h0000_4220.
  - Read-only Config (16) = 32'h8000_0000.
  - MTC0 writes to 15 and 16 are ignored.
- Undefined: addresses 15 and 16 read 0.

Decomposition:
- Shared package cp0_pkg:
  - CP0 register numbers.
  - ExcCode constants.
  - Status/Cause bit positions.
  - exc_vec bit indices.
- One sub-module: cp0_timer, holding the divider, Count, Compare and TI set/clear logic.
- Synchroniser and priority encoder stay inline.

Test Plan:
- Reset, TIMER_DIV=2, Compare=5 → TI=1 when Count reaches 5 (≈10 cycles); MTC0 Compare=20 → TI=0.
- Status=0x0000_8001, TI pending, commit_valid, pc=0x8000_1000 → flush=1, new_pc=0xbfc00380, EPC=0x8000_1000, ExcCode=0, EXL=1.
- exc_vec ov+ades together, bd=1, pc=0x8000_2004 → ExcCode=0xC, EPC=0x8000_2000, BD=1, BadVAddr unchanged.
- ades alone, bad_addr=0x1234_5671 → ExcCode=5, BadVAddr=0x1234_5671; then ERET → new_pc=EPC, EXL=0.
- hw_int[0] asserted with IM2=1 and IE=1 → exception taken no earlier than INT_SYNC_STAGES+1 cycles after assertion; with EXL=1 it is never taken.
- MTC0 Count=0xFFFF_FFFF during an increment cycle → 0xFFFF_FFFF, then wraps to 0 on the next increment.
